// File: rtl/ysyx_ifu_mem_responder_pkg.sv
// Shared types and codes for the IFU fetch-port memory responder.
// Holds the FSM state encoding, response codes and counter width.
package ysyx_ifu_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // LATENCY-1 (max 14) plus RAND_EXTRA (max 15) always fits in 5 bits.
    localparam int CNT_W = 5;

endpackage

// File: rtl/ysyx_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that steps only when en is high.
// A nonzero seed is loaded on synchronous reset.
module ysyx_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic feedback;

    assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed;
        end else if (en) begin
            q <= {q[6:0], feedback};
        end
    end

endmodule

// File: rtl/ysyx_ifu_mem_responder.sv
// Read responder for the IFU fetch port, backed by a word-addressed SRAM
// with programmable (optionally LFSR-jittered) latency and a preload port.
module ysyx_ifu_mem_responder
    import ysyx_ifu_mem_responder_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 4096,
    parameter logic [ADDR_W-1:0] BASE       = 'h8000_0000,
    parameter int                LATENCY    = 1,
    parameter int                RAND_EXTRA = 0,
    parameter logic [7:0]        LFSR_SEED  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rvalid_o,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_wdata_i,
    output logic [1:0]        state_o
);

    localparam int IDX_W = $clog2(DEPTH);

    // Handshake: a request is taken on a cycle with arvalid_i & arready_o;
    // the answer is a single-cycle rvalid_o pulse with no back-pressure,
    // so the initiator must capture rdata_o/rresp_o in that very cycle.

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        lfsr_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic [CNT_W-1:0]  cnt_load;

    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_off;
    logic              rd_hit;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic [1:0]        rd_resp;

    logic [ADDR_W-1:0] wr_off;
    logic              wr_hit;
    logic [IDX_W-1:0]  wr_idx;

    assign state_o = state_q;
    assign accept  = (state_q == ST_IDLE) && arvalid_i;

    ysyx_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    // With RAND_EXTRA=0 the modulo is by 1, so the jitter collapses to zero.
    assign cnt_load = CNT_W'(32'(LATENCY - 1) + 32'(lfsr_q % 8'(RAND_EXTRA + 1)));

    // A zero-count accept goes straight to RESP, so decode the live address then.
    assign rd_addr = (state_q == ST_IDLE) ? araddr_i : addr_q;
    assign rd_off  = rd_addr - BASE;
    assign rd_hit  = (rd_off >> (IDX_W + 2)) == '0;
    assign rd_idx  = rd_off[IDX_W+1:2];
    assign rd_word = rd_hit ? mem[rd_idx] : '0;
    assign rd_resp = rd_hit ? RESP_OKAY : RESP_SLVERR;

    assign wr_off = prog_addr_i - BASE;
    assign wr_hit = (wr_off >> (IDX_W + 2)) == '0;
    assign wr_idx = wr_off[IDX_W+1:2];

    // The FSM samples mem on the same edge, so a colliding write reads old data.
    always_ff @(posedge clk) begin
        if (prog_we_i && wr_hit) begin
            mem[wr_idx] <= prog_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            arready_o <= 1'b1;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            rresp_o   <= RESP_OKAY;
        end else begin
            rvalid_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arvalid_i) begin
                        addr_q    <= araddr_i;
                        arready_o <= 1'b0;
                        if (cnt_load == '0) begin
                            state_q  <= ST_RESP;
                            rvalid_o <= 1'b1;
                            rdata_o  <= rd_word;
                            rresp_o  <= rd_resp;
                        end else begin
                            state_q <= ST_BUSY;
                            cnt_q   <= cnt_load;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q    <= '0;
                        state_q  <= ST_RESP;
                        rvalid_o <= 1'b1;
                        rdata_o  <= rd_word;
                        rresp_o  <= rd_resp;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_q   <= ST_IDLE;
                    arready_o <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    arready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_ifu_mem_responder.sv
// Bench for ysyx_ifu_mem_responder: three instances (fixed, long, jittered
// latency) share stimulus; one is selected at a time for checking.
module tb_ysyx_ifu_mem_responder;
    import ysyx_ifu_mem_responder_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_wdata = '0;

    logic        f_arready, f_rvalid, l_arready, l_rvalid, r_arready, r_rvalid;
    logic [31:0] f_rdata, l_rdata, r_rdata;
    logic [1:0]  f_rresp, l_rresp, r_rresp, f_state, l_state, r_state;

    int          sel = 0;
    logic        m_arready, m_rvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp, m_state;

    int n_tests = 0;
    int n_fail = 0;

    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] busy_addr;
        int          sel;
        logic [31:0] data;
        logic [1:0]  resp;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ysyx_ifu_mem_responder #(.LATENCY(1), .RAND_EXTRA(0)) u_fix (
        .clk(clk), .rst(rst), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(f_arready),
        .rdata_o(f_rdata), .rresp_o(f_rresp), .rvalid_o(f_rvalid), .prog_we_i(prog_we),
        .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata), .state_o(f_state)
    );
    ysyx_ifu_mem_responder #(.LATENCY(4), .RAND_EXTRA(0)) u_long (
        .clk(clk), .rst(rst), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(l_arready),
        .rdata_o(l_rdata), .rresp_o(l_rresp), .rvalid_o(l_rvalid), .prog_we_i(prog_we),
        .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata), .state_o(l_state)
    );
    ysyx_ifu_mem_responder #(.LATENCY(2), .RAND_EXTRA(3)) u_rand (
        .clk(clk), .rst(rst), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(r_arready),
        .rdata_o(r_rdata), .rresp_o(r_rresp), .rvalid_o(r_rvalid), .prog_we_i(prog_we),
        .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata), .state_o(r_state)
    );

    always_comb begin
        m_arready = f_arready;
        m_rvalid  = f_rvalid;
        m_rdata   = f_rdata;
        m_rresp   = f_rresp;
        m_state   = f_state;
        case (sel)
            1: begin
                m_arready = l_arready; m_rvalid = l_rvalid; m_rdata = l_rdata;
                m_rresp = l_rresp; m_state = l_state;
            end
            2: begin
                m_arready = r_arready; m_rvalid = r_rvalid; m_rdata = r_rdata;
                m_rresp = r_rresp; m_state = r_state;
            end
            default: ;
        endcase
    end

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        if (!in_rng(a)) return '0;
        return model_mem[int'((a - BASE) >> 2)];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        if (in_rng(a)) model_mem[int'((a - BASE) >> 2)] = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    // One request; reports arready in T, data/resp/latency of the response,
    // whether arready stayed low until the response, and that rvalid was a pulse.
    task automatic read_req(input logic [31:0] addr, input logic [31:0] busy_addr,
                            input bit wr_en, input logic [31:0] wr_data,
                            output logic [31:0] d, output logic [1:0] r, output int lat,
                            output logic art, output bit busy_ok, output bit pulse_ok);
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        prog_we = wr_en; prog_addr = addr; prog_wdata = wr_data;
        @(negedge clk);
        art = m_arready;
        @(posedge clk); #1;
        arvalid = 1'b0; araddr = busy_addr; prog_we = 1'b0;
        lat = 0; busy_ok = 1'b1; pulse_ok = 1'b1; d = '0; r = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (m_arready !== 1'b0) busy_ok = 1'b0;
            if (m_rvalid === 1'b1) begin
                lat = k; d = m_rdata; r = m_rresp;
                break;
            end
        end
        @(negedge clk);
        if (m_rvalid !== 1'b0) pulse_ok = 1'b0;
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic        art;
    bit          busy_ok, pulse_ok, seen;
    int          hist[4];
    logic [31:0] a;

    initial begin
        // Reset state
        idle(3);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset arready", 32'(f_arready), 32'd1);
        chk("reset rvalid", 32'(f_rvalid), 32'd0);
        chk("reset rdata", f_rdata, 32'd0);
        chk("reset rresp", 32'(f_rresp), 32'd0);
        chk("reset state", 32'(f_state), 32'(ST_IDLE));

        // Preload, including two writes that must be dropped as out of range
        prog_write(BASE + 32'h0,  32'h0000_0413);
        prog_write(BASE + 32'h4,  32'h0010_0093);
        prog_write(BASE + 32'h8,  32'h0020_0113);
        prog_write(BASE + 32'hC,  32'h0030_0193);
        prog_write(BASE + 32'h10, 32'h0040_0213);
        prog_write(BASE + 32'h14, 32'h5555_AAAA);
        for (int i = 6; i < 64; i++) prog_write(BASE + 32'(i * 4), $urandom);
        prog_write(BASE + 32'h3FFC, 32'hCAFE_F00D);
        prog_write(32'h8000_4000, 32'h1234_5678);
        prog_write(32'h7FFF_FFFC, 32'h8765_4321);

        // addr, busy_addr, sel, data, resp, latency
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 0, 32'h0000_0413, 2'b00, 1});
        vecs.push_back('{32'h8000_0007, 32'h8000_0007, 0, 32'h0010_0093, 2'b00, 1});
        vecs.push_back('{32'h8000_4000, 32'h0,         0, 32'h0,         2'b10, 1});
        vecs.push_back('{32'h7FFF_FFFC, 32'h0,         0, 32'h0,         2'b10, 1});
        vecs.push_back('{32'h8000_3FFC, 32'h0,         0, 32'hCAFE_F00D, 2'b00, 1});
        vecs.push_back('{32'hFFFF_FFFC, 32'h0,         0, 32'h0,         2'b10, 1});
        vecs.push_back('{32'h8000_0000, 32'h8000_0004, 1, 32'h0000_0413, 2'b00, 4});
        vecs.push_back('{32'h8000_000A, 32'h8000_4000, 1, 32'h0020_0113, 2'b00, 4});
        vecs.push_back('{32'h8000_4000, 32'h8000_0000, 1, 32'h0,         2'b10, 4});
        vecs.push_back('{32'h7FFF_FFFC, 32'h8000_000C, 1, 32'h0,         2'b10, 4});

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            idle(6);
            read_req(vecs[i].addr, vecs[i].busy_addr, 1'b0, '0, d, r, lat, art, busy_ok, pulse_ok);
            chk($sformatf("vec%0d arready", i), 32'(art), 32'd1);
            chk($sformatf("vec%0d data", i), d, vecs[i].data);
            chk($sformatf("vec%0d resp", i), 32'(r), 32'(vecs[i].resp));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d busy arready", i), 32'(busy_ok), 32'd1);
            chk($sformatf("vec%0d pulse", i), 32'(pulse_ok), 32'd1);
        end

        // Back-to-back: arvalid held for 10 cycles, responses every other cycle
        sel = 0;
        idle(6);
        @(posedge clk); #1;
        araddr = 32'h8000_0007; arvalid = 1'b1;
        for (int p = 0; p < 12; p++) begin
            @(negedge clk);
            chk($sformatf("b2b rvalid p%0d", p), 32'(m_rvalid), 32'((p % 2 == 1) && (p <= 9)));
            chk($sformatf("b2b arready p%0d", p), 32'(m_arready), 32'(!((p % 2 == 1) && (p <= 9))));
            if (m_rvalid === 1'b1) chk($sformatf("b2b rdata p%0d", p), m_rdata, 32'h0010_0093);
            @(posedge clk); #1;
            if (p == 9) arvalid = 1'b0;
        end

        // Preload write colliding with the RESP-entry cycle
        idle(4);
        read_req(32'h8000_0014, 32'h8000_0014, 1'b1, 32'hDEAD_BEEF, d, r, lat, art, busy_ok, pulse_ok);
        chk("collide old data", d, 32'h5555_AAAA);
        chk("collide latency", 32'(lat), 32'd1);
        model_mem[5] = 32'hDEAD_BEEF;
        read_req(32'h8000_0014, 32'h8000_0014, 1'b0, '0, d, r, lat, art, busy_ok, pulse_ok);
        chk("collide new data", d, 32'hDEAD_BEEF);

        // Reset while BUSY drops the response
        sel = 1;
        idle(6);
        @(posedge clk); #1;
        araddr = 32'h8000_0000; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("rstmid busy", 32'(m_state), 32'(ST_BUSY));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid arready", 32'(m_arready), 32'd1);
        chk("rstmid state", 32'(m_state), 32'(ST_IDLE));
        seen = 1'b0;
        if (m_rvalid !== 1'b0) seen = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (m_rvalid !== 1'b0) seen = 1'b1;
        end
        chk("rstmid no rvalid", 32'(seen), 32'd0);

        // Random requests against the jittered instance (LATENCY=2, RAND_EXTRA=3)
        sel = 2;
        idle(8);
        for (int j = 0; j < 4; j++) hist[j] = 0;
        for (int n = 0; n < 1000; n++) begin
            int c;
            c = $urandom_range(0, 9);
            if (c < 8)       a = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            else if (c == 8) a = BASE + 32'h4000 + 32'($urandom_range(0, 1023) * 4);
            else             a = BASE - 32'($urandom_range(1, 1000) * 4);
            if ($urandom_range(0, 9) == 0) prog_write(BASE + 32'($urandom_range(0, 63) * 4), $urandom);
            idle($urandom_range(0, 2));
            read_req(a, $urandom, 1'b0, '0, d, r, lat, art, busy_ok, pulse_ok);
            chk($sformatf("rand%0d data", n), d, exp_data(a));
            chk($sformatf("rand%0d resp", n), 32'(r), in_rng(a) ? 32'd0 : 32'd2);
            chk($sformatf("rand%0d lat range", n), 32'(lat >= 2 && lat <= 5), 32'd1);
            if (lat >= 2 && lat <= 5) hist[lat - 2]++;
        end
        for (int j = 0; j < 4; j++) chk($sformatf("rand latency %0d seen", j + 2), 32'(hist[j] > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
